memory_stage: RTL and testbench



---
 rtl/memory_stage_pkg.sv | 29 ++
 rtl/memory_stage_if.sv | 32 +++
 rtl/memory_stage_data_mem.sv | 40 ++++
 rtl/memory_stage.sv | 121 ++++++++++++
 tb/tb_memory_stage.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the SEQ memory stage: instruction codes, status
// codes and the clear/run/halt state encoding.
package memory_stage_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/memory_stage_if.sv
// Execute-to-memory bundle. The master (execute side) drives the instruction
// fields; the slave (memory stage) returns valM, status and its FSM state.
interface memory_stage_if;
  import memory_stage_pkg::*;

  // Handshake: an instruction is consumed on a rising edge where
  // instr_valid=1 and ready=1. There is no backpressure once ready is high;
  // valid without ready (during the clear sweep) is simply ignored.
  logic        instr_valid;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        imem_error;
  logic        instr_invalid;
  logic        ready;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;
  logic        halted;
  state_t      dbg_state;

  modport master (
    output instr_valid, icode, valE, valA, valP, imem_error, instr_invalid,
    input  ready, valM, dmem_error, stat, halted, dbg_state
  );

  modport slave (
    input  instr_valid, icode, valE, valA, valP, imem_error, instr_invalid,
    output ready, valM, dmem_error, stat, halted, dbg_state
  );
endinterface

// File: rtl/memory_stage_data_mem.sv
// Byte-addressed data memory: 8-byte little-endian combinational read,
// one synchronous 8-byte write port and a chunked zeroing port.
module memory_stage_data_mem #(
  parameter int MEM_BYTES = 1024,
  parameter int CLR_BYTES = 8,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[raddr + AW'(i)];
    end
  end

  // Clear and write never coincide: the owner only clears outside RUN.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < CLR_BYTES; i++) begin
        mem[clr_addr + AW'(i)] <= 8'h00;
      end
    end else if (we) begin
      for (int i = 0; i < 8; i++) begin
        mem[waddr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// SEQ memory stage: decodes the data access for the current instruction,
// range-checks it, computes status and owns the clear/run/halt sequencing.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int MEM_BYTES         = 1024,
  parameter int CLR_BYTES_PER_CYC = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  memory_stage_if.slave  bus
);

  localparam int          AW       = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
  localparam logic [AW-1:0] CLR_STEP = AW'(CLR_BYTES_PER_CYC);
  localparam logic [AW-1:0] CLR_LAST = AW'(MEM_BYTES - CLR_BYTES_PER_CYC);

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic          ready_q;
  logic          halted_q;
  logic [2:0]    stat_q;

  logic          is_rd;
  logic          is_wr;
  logic [63:0]   addr;
  logic [63:0]   wdata;
  logic          addr_err;
  logic [2:0]    stat_calc;
  logic          run_valid;
  logic          halt_now;
  logic          mem_we;
  logic [63:0]   rdata;

  always_comb begin
    is_rd = (bus.icode == I_MRMOVQ) || (bus.icode == I_RET) || (bus.icode == I_POPQ);
    is_wr = (bus.icode == I_RMMOVQ) || (bus.icode == I_CALL) || (bus.icode == I_PUSHQ);
    addr  = (bus.icode == I_MRMOVQ || is_wr) ? bus.valE : bus.valA;
    wdata = (bus.icode == I_CALL) ? bus.valP : bus.valA;
  end

  // Full 64-bit compare so huge addresses never alias back into the array.
  assign addr_err  = (is_rd || is_wr) && (addr > ADDR_MAX);
  assign run_valid = (state == ST_RUN) && bus.instr_valid;

  always_comb begin
    stat_calc = STAT_AOK;
    if (bus.imem_error) begin
      stat_calc = STAT_ADR;
    end else if (bus.instr_invalid) begin
      stat_calc = STAT_INS;
    end else if (addr_err) begin
      stat_calc = STAT_ADR;
    end else if (bus.icode == I_HALT) begin
      stat_calc = STAT_HLT;
    end
  end

  assign halt_now = run_valid && (stat_calc != STAT_AOK);
  assign mem_we   = run_valid && is_wr && !addr_err && !bus.imem_error && !bus.instr_invalid;

  memory_stage_data_mem #(
    .MEM_BYTES (MEM_BYTES),
    .CLR_BYTES (CLR_BYTES_PER_CYC),
    .AW        (AW)
  ) u_mem (
    .clk      (clk),
    .we       (mem_we),
    .waddr    (addr[AW-1:0]),
    .wdata    (wdata),
    .clr_en   (rst_n && (state == ST_CLEAR)),
    .clr_addr (clr_ptr),
    .raddr    (addr[AW-1:0]),
    .rdata    (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_ptr  <= '0;
      ready_q  <= 1'b0;
      halted_q <= 1'b0;
      stat_q   <= STAT_AOK;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_ptr == CLR_LAST) begin
            state   <= ST_RUN;
            ready_q <= 1'b1;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + CLR_STEP;
          end
        end
        ST_RUN: begin
          if (halt_now) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
            stat_q   <= stat_calc;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_CLEAR;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.halted     = halted_q;
  assign bus.dbg_state  = state;
  assign bus.dmem_error = run_valid && addr_err;
  assign bus.valM       = (run_valid && is_rd && !addr_err) ? rdata : 64'h0;
  assign bus.stat       = (state == ST_HALT) ? stat_q :
                          run_valid          ? stat_calc : STAT_AOK;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: clear timing, read/write round trips,
// range faults, status priority and reset behaviour.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int MEM_BYTES = 1024;
  localparam int CLR       = 8;
  localparam int W         = 68;

  logic clk;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  logic [W-1:0] exp_q[$];

  memory_stage_if bus ();

  memory_stage #(
    .MEM_BYTES         (MEM_BYTES),
    .CLR_BYTES_PER_CYC (CLR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.instr_valid   = 1'b0;
    bus.icode         = I_NOP;
    bus.valE          = '0;
    bus.valA          = '0;
    bus.valP          = '0;
    bus.imem_error    = 1'b0;
    bus.instr_invalid = 1'b0;
  endtask

  // Count edges from rst_n release until ready; bounded.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 64'(n), 64'(MEM_BYTES / CLR));
    @(negedge clk);
  endtask

  // Called at a negedge. Holds reset for two edges, checks reset state,
  // releases reset and measures the clear sweep.
  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "/ready"},  64'(bus.ready), 64'(0));
    check({tag, "/halted"}, 64'(bus.halted), 64'(0));
    check({tag, "/state"},  64'(bus.dbg_state), 64'(ST_CLEAR));
    check({tag, "/stat"},   64'(bus.stat), 64'(STAT_AOK));
    rst_n = 1'b1;
    wait_ready({tag, "/clr_cycles"});
  endtask

  // Driver + scoreboard: push expectation, drive, pop and compare mid-cycle.
  task automatic issue(input string tag, input logic v, input logic [3:0] ic,
                       input logic [63:0] e, input logic [63:0] a, input logic [63:0] p,
                       input logic ie, input logic ii,
                       input logic [63:0] exp_valm, input logic exp_derr,
                       input logic [2:0] exp_stat);
    logic [W-1:0] item;
    bus.instr_valid   = v;
    bus.icode         = ic;
    bus.valE          = e;
    bus.valA          = a;
    bus.valP          = p;
    bus.imem_error    = ie;
    bus.instr_invalid = ii;
    exp_q.push_back({exp_stat, exp_derr, exp_valm});
    #2;
    if (exp_q.size() == 0) begin
      check({tag, "/queue"}, 64'(0), 64'(1));
    end else begin
      item = exp_q.pop_front();
      check({tag, "/valM"}, bus.valM, item[63:0]);
      check({tag, "/dmem_error"}, 64'(bus.dmem_error), 64'(item[64]));
      check({tag, "/stat"}, 64'(bus.stat), 64'(item[67:65]));
    end
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic check_halted(input string tag, input logic [2:0] exp_stat);
    check({tag, "/halted"}, 64'(bus.halted), 64'(1));
    check({tag, "/state"},  64'(bus.dbg_state), 64'(ST_HALT));
    check({tag, "/stat"},   64'(bus.stat), 64'(exp_stat));
    check({tag, "/ready"},  64'(bus.ready), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset("rst0");

    issue("rd_top_cleared", 1, I_MRMOVQ, 64'h3F8, 0, 0, 0, 0, 64'h0, 0, STAT_AOK);
    issue("wr_unaligned", 1, I_RMMOVQ, 64'h101, 64'h0123456789ABCDEF, 0, 0, 0, 64'h0, 0, STAT_AOK);
    issue("rd_unaligned", 1, I_MRMOVQ, 64'h101, 0, 0, 0, 0, 64'h0123456789ABCDEF, 0, STAT_AOK);
    issue("rd_shifted", 1, I_MRMOVQ, 64'h100, 0, 0, 0, 0, 64'h23456789ABCDEF00, 0, STAT_AOK);
    issue("pushq", 1, I_PUSHQ, 64'h200, 64'h55, 0, 0, 0, 64'h0, 0, STAT_AOK);
    issue("popq", 1, I_POPQ, 64'h0, 64'h200, 0, 0, 0, 64'h55, 0, STAT_AOK);
    issue("call", 1, I_CALL, 64'h1F8, 64'h777, 64'h40, 0, 0, 64'h0, 0, STAT_AOK);
    issue("ret", 1, I_RET, 64'h0, 64'h1F8, 0, 0, 0, 64'h40, 0, STAT_AOK);
    issue("rd_last_word", 1, I_MRMOVQ, 64'h3F8, 0, 0, 0, 0, 64'h0, 0, STAT_AOK);
    // Not valid: halt icode with faults must be ignored entirely.
    issue("invalid_slot", 0, I_HALT, 64'hFFFF, 0, 0, 1, 1, 64'h0, 0, STAT_AOK);
    check("invalid_slot/halted", 64'(bus.halted), 64'(0));
    check("invalid_slot/state", 64'(bus.dbg_state), 64'(ST_RUN));

    // Write one past the last legal base address faults and halts.
    issue("wr_oob", 1, I_RMMOVQ, 64'h3F9, 64'hA5A5A5A5A5A5A5A5, 0, 0, 0, 64'h0, 1, STAT_ADR);
    check_halted("wr_oob", STAT_ADR);
    check("wr_oob/no_write", 64'(dut.u_mem.mem[10'h3F9]), 64'(0));
    issue("halt_wr", 1, I_RMMOVQ, 64'h0, 64'hDEADBEEFDEADBEEF, 0, 0, 0, 64'h0, 0, STAT_ADR);
    check("halt_wr/no_write_b0", 64'(dut.u_mem.mem[0]), 64'(0));
    check("halt_wr/no_write_b7", 64'(dut.u_mem.mem[7]), 64'(0));
    issue("halt_rd", 1, I_MRMOVQ, 64'h101, 0, 0, 0, 0, 64'h0, 0, STAT_ADR);
    check_halted("halt_hold", STAT_ADR);

    do_reset("rst_halted");
    issue("rd_after_reclear", 1, I_MRMOVQ, 64'h101, 0, 0, 0, 0, 64'h0, 0, STAT_AOK);

    issue("halt_instr", 1, I_HALT, 0, 0, 0, 0, 0, 64'h0, 0, STAT_HLT);
    check_halted("halt_instr", STAT_HLT);
    do_reset("rst_hlt");

    issue("imem_err", 1, I_HALT, 0, 0, 0, 1, 0, 64'h0, 0, STAT_ADR);
    check_halted("imem_err", STAT_ADR);
    do_reset("rst_imem");

    issue("instr_inv", 1, 4'hC, 0, 0, 0, 0, 1, 64'h0, 0, STAT_INS);
    check_halted("instr_inv", STAT_INS);
    do_reset("rst_inv");

    issue("rd_wrap", 1, I_MRMOVQ, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 64'h0, 1, STAT_ADR);
    check_halted("rd_wrap", STAT_ADR);

    // Reset again, then interrupt the sweep at cycle 50.
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("mid_sweep/ready", 64'(bus.ready), 64'(0));
    check("mid_sweep/state", 64'(bus.dbg_state), 64'(ST_CLEAR));
    do_reset("rst_mid");
    issue("rd_after_mid", 1, I_MRMOVQ, 64'h200, 0, 0, 0, 0, 64'h0, 0, STAT_AOK);
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
